// File: rtl/slip_rx.sv
// rtl/slip_rx.sv - SLIP frame decoder with output FIFO
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in, in_clk         received byte and its update pulse (one byte per rising edge)
//   out, out_last      FIFO head entry: decoded byte and end-of-frame flag
//   out_valid          FIFO not empty
//   out_ready          consumer accepts the head entry this cycle
//   err                one-cycle pulse on protocol error or overflow
module slip_rx #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    input  logic       in_clk,
    output logic [7:0] out,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [7:0] END_B   = 8'hC0;
    localparam logic [7:0] ESC_B   = 8'hDB;
    localparam logic [7:0] ESC_END = 8'hDC;
    localparam logic [7:0] ESC_ESC = 8'hDD;

    typedef enum logic [1:0] {
        NORM    = 2'd0,
        ESC     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic        in_clk_d_q, in_clk_d_d;
    logic        err_q, err_d;
    logic [8:0]  mem_q [DEPTH];
    logic [8:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic       stb;
    logic       push_req;
    logic [8:0] push_data;
    logic       abort;
    logic       pop;
    logic       overflow;
    logic       do_push;

    assign stb = in_clk & ~in_clk_d_q;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        in_clk_d_d = in_clk;
        push_req   = 1'b0;
        push_data  = 9'h000;
        abort      = 1'b0;

        if (stb) begin
            case (state_q)
                NORM: begin
                    if (in == END_B) begin
                        // An END with nothing pending is an empty frame: drop it.
                        if (pend_v_q) begin
                            push_req  = 1'b1;
                            push_data = {1'b1, pend_q};
                        end
                        pend_v_d = 1'b0;
                    end else if (in == ESC_B) begin
                        state_d = ESC;
                    end else begin
                        if (pend_v_q) begin
                            push_req  = 1'b1;
                            push_data = {1'b0, pend_q};
                        end
                        pend_d   = in;
                        pend_v_d = 1'b1;
                    end
                end
                ESC: begin
                    if (in == ESC_END || in == ESC_ESC) begin
                        if (pend_v_q) begin
                            push_req  = 1'b1;
                            push_data = {1'b0, pend_q};
                        end
                        pend_d   = (in == ESC_END) ? END_B : ESC_B;
                        pend_v_d = 1'b1;
                        state_d  = NORM;
                    end else begin
                        // Bad escape: close what we have as a (truncated) frame.
                        if (pend_v_q) begin
                            push_req  = 1'b1;
                            push_data = {1'b1, pend_q};
                        end
                        pend_v_d = 1'b0;
                        abort    = 1'b1;
                        state_d  = (in == END_B) ? NORM : DISCARD;
                    end
                end
                default: begin
                    if (in == END_B) begin
                        state_d = NORM;
                    end
                end
            endcase
        end

        pop      = (count_q != '0) & out_ready;
        overflow = push_req & (count_q == FULL_CNT) & ~pop;
        do_push  = push_req & ~overflow;

        // Overflow wins over whatever the decoder wanted: the rest of the
        // frame is unusable, so skip to the next END.
        if (overflow) begin
            pend_v_d = 1'b0;
            state_d  = DISCARD;
        end

        err_d = abort | overflow;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        count_d = count_q;
        if (do_push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!do_push && pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= NORM;
            pend_q     <= 8'h00;
            pend_v_q   <= 1'b0;
            in_clk_d_q <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 9'h000;
            end
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            in_clk_d_q <= in_clk_d_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign out       = mem_q[rd_ptr_q][7:0];
    assign out_last  = mem_q[rd_ptr_q][8];
    assign out_valid = (count_q != '0);
    assign err       = err_q;

endmodule

// File: tb/tb_slip_rx.sv
// tb/tb_slip_rx.sv - self-checking bench for slip_rx
module tb_slip_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_b;
    logic       in_clk;
    logic [7:0] out;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    slip_rx #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_b),
        .in_clk    (in_clk),
        .out       (out),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Monitor: inputs change 1 time unit after posedge, so values at negedge
    // are exactly what the next posedge will act on.
    logic [8:0] recv[$];
    int         err_cnt = 0;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) recv.push_back({out_last, out});
        if (err) err_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk) #1;
        in_b   = b;
        in_clk = 1'b1;
        @(posedge clk) #1;
        in_clk = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare recv[rb..] against up to 5 expected entries, first in MSBs.
    task automatic chk_entries(input string name, input int rb, input logic [44:0] exp, input int n);
        logic [8:0] a;
        chk({name, "_len"}, 32'(recv.size() - rb), 32'(n));
        for (int j = 0; j < n; j++) begin
            a = (rb + j < recv.size()) ? recv[rb + j] : 9'h1FF;
            chk($sformatf("%s_e%0d", name, j), 32'(a), 32'(exp[9*(4-j) +: 9]));
        end
    endtask

    typedef struct {
        int          n_in;
        logic [63:0] bytes_in;
        int          n_out;
        logic [44:0] outs;
        int          n_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rb;
        int eb;

        vecs[0] = '{3, 64'h41_42_C0_00_00_00_00_00, 2, {9'h041, 9'h142, 9'h0, 9'h0, 9'h0}, 0};
        vecs[1] = '{3, 64'hC0_C0_C0_00_00_00_00_00, 0, 45'h0, 0};
        vecs[2] = '{6, 64'h41_DB_DC_DB_DD_C0_00_00, 3, {9'h041, 9'h0C0, 9'h1DB, 9'h0, 9'h0}, 0};
        vecs[3] = '{7, 64'h41_DB_55_77_C0_61_C0_00, 2, {9'h141, 9'h161, 9'h0, 9'h0, 9'h0}, 1};
        vecs[4] = '{4, 64'hDB_C0_62_C0_00_00_00_00, 1, {9'h162, 9'h0, 9'h0, 9'h0, 9'h0}, 1};
        vecs[5] = '{5, 64'h41_DB_C0_43_C0_00_00_00, 2, {9'h141, 9'h143, 9'h0, 9'h0, 9'h0}, 1};

        rst_n     = 1'b0;
        in_b      = 8'h00;
        in_clk    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", 32'(out), 32'h00);
        chk("rst_last", 32'(out_last), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        @(posedge clk) #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Table-driven frames with a ready consumer
        for (int v = 0; v < 6; v++) begin
            rb = recv.size();
            eb = err_cnt;
            for (int i = 0; i < vecs[v].n_in; i++) send_byte(vecs[v].bytes_in[8*(7-i) +: 8]);
            settle(4);
            chk_entries($sformatf("vec%0d", v), rb, vecs[v].outs, vecs[v].n_out);
            chk($sformatf("vec%0d_err", v), 32'(err_cnt - eb), 32'(vecs[v].n_err));
            chk($sformatf("vec%0d_idle", v), 32'(out_valid), 32'h0);
        end

        // Overflow with a stalled consumer
        out_ready = 1'b0;
        rb = recv.size();
        eb = err_cnt;
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        settle(2);
        chk("ovf_head", 32'({out_last, out}), 32'h001);
        chk("ovf_noerr_yet", 32'(err_cnt - eb), 32'h0);
        send_byte(8'h06);
        settle(2);
        chk("ovf_err", 32'(err_cnt - eb), 32'h1);
        send_byte(8'h07);
        send_byte(8'hC0);
        send_byte(8'h88);
        settle(2);
        chk("ovf_err_once", 32'(err_cnt - eb), 32'h1);
        @(posedge clk) #1;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && out_valid; i++) @(negedge clk);
        chk("ovf_drain_timeout", 32'(out_valid), 32'h0);
        send_byte(8'hC0);
        settle(4);
        chk_entries("ovf", rb, {9'h001, 9'h002, 9'h003, 9'h004, 9'h188}, 5);
        chk("ovf_err_final", 32'(err_cnt - eb), 32'h1);

        // Full FIFO, push coinciding with pop
        out_ready = 1'b0;
        rb = recv.size();
        eb = err_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
        @(posedge clk) #1;
        in_b      = 8'h16;
        in_clk    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk) #1;
        in_clk    = 1'b0;
        out_ready = 1'b0;
        settle(2);
        chk("full_pp_noerr", 32'(err_cnt - eb), 32'h0);
        // If the count stayed at DEPTH, this push must overflow.
        send_byte(8'h17);
        settle(2);
        chk("full_pp_count", 32'(err_cnt - eb), 32'h1);
        send_byte(8'hC0);
        @(posedge clk) #1;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && out_valid; i++) @(negedge clk);
        chk("full_drain_timeout", 32'(out_valid), 32'h0);
        settle(2);
        chk_entries("full", rb, {9'h011, 9'h012, 9'h013, 9'h014, 9'h015}, 5);

        // Long in_clk pulse counts as one byte
        rb = recv.size();
        eb = err_cnt;
        @(posedge clk) #1;
        in_b   = 8'h41;
        in_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_clk = 1'b0;
        send_byte(8'hC0);
        settle(4);
        chk_entries("pulse", rb, {9'h141, 9'h0, 9'h0, 9'h0, 9'h0}, 1);

        // Reset mid-frame discards everything
        out_ready = 1'b0;
        send_byte(8'h41);
        send_byte(8'h42);
        settle(2);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        @(posedge clk) #1;
        rst_n = 1'b0;
        @(posedge clk) #1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        chk("mid_rst_out", 32'(out), 32'h00);
        @(posedge clk) #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        rb = recv.size();
        send_byte(8'h43);
        send_byte(8'hC0);
        settle(4);
        chk_entries("post_rst", rb, {9'h143, 9'h0, 9'h0, 9'h0, 9'h0}, 1);
        chk("rst_seq_err", 32'(err_cnt - eb), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
